lsu_mem_responder: RTL and testbench
====================================

# lsu_mem_responder

Data-memory responder that serves the per-thread load-store units on the consumer side of their valid/ready memory handshake. It round-robin arbitrates among `NUM_CONSUMERS` read/write request channels and serves one request at a time against an internal byte-addressed memory with a fixed access latency. It returns single-cycle ready pulses with read data. It stands in for the external data memory and controller in core-level simulation and FPGA builds.

## Interface
- `NUM_CONSUMERS`, 4: number of request channels (LSUs); 1..16.
- `ADDR_BITS`, 8: address width; the memory has 2^ADDR_BITS entries.
- `DATA_BITS`, 8: data width.
- `LATENCY`, 2: cycles spent in BUSY per request; must be at least 1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `consumer_read_valid`  in  [NUM_CONSUMERS]  per-channel read request; held high until that channel's ready is seen.
- `consumer_read_address`  in  [NUM_CONSUMERS][ADDR_BITS]  read address per channel.
- `consumer_read_ready`  out  [NUM_CONSUMERS]  one-cycle read completion pulse per channel.
- `consumer_read_data`  out  [NUM_CONSUMERS][DATA_BITS]  read data; valid while ready is high, holds its value afterwards.
- `consumer_write_valid`  in  [NUM_CONSUMERS]  per-channel write request.
- `consumer_write_address`  in  [NUM_CONSUMERS][ADDR_BITS]  write address.
- `consumer_write_data`  in  [NUM_CONSUMERS][DATA_BITS]  write data.
- `consumer_write_ready`  out  [NUM_CONSUMERS]  one-cycle write completion pulse.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- The FSM has three states: IDLE, BUSY and RESPOND.
- **IDLE**
  - A channel is eligible when its `read_valid` or its `write_valid` is high.
  - The grant search starts at `last_grant+1` and wraps modulo `NUM_CONSUMERS`. The first eligible channel wins.
  - On a grant, the responder latches the channel index, the operation (read or write), the address and the write data, loads `count = LATENCY-1`, moves to BUSY and sets `last_grant` to the winning channel.
  - If neither request of any channel is high, the FSM stays in IDLE.
- **Same-channel read and write:** if one channel has both read and write valid, the read is served first. The write is taken on a later grant of that channel.
- **BUSY**
  - While `count != 0`, the counter decrements.
  - When `count == 0`, the FSM moves to RESPOND. At the same edge:
    - for a write, `mem[addr] <= data`;
    - for a read, `consumer_read_data[ch] <= mem[addr]`.
  - The request inputs are ignored during BUSY. If a valid drops mid-request (a protocol violation), the request still completes.
- **RESPOND**
  - The latched channel's `read_ready` or `write_ready` is high for exactly this cycle; all other ready bits are 0.
  - The next state is always IDLE, and no grant is made in RESPOND. This is required because the LSU drops valid only on the edge where it samples ready, so the dead cycle prevents a duplicate grant of the same request.
- **Arbitration pointer:** resets to `NUM_CONSUMERS-1`, so channel 0 has first priority after reset.
- **Ordering:** requests are serialized, so a read granted after a write to the same address returns the new data.
- **Addressing:** addresses are used directly; there is no wrap or out-of-range case because the depth is exactly 2^ADDR_BITS.

## Timing
- **Reset (async, effective immediately)**
  - State is IDLE, `count` is 0 and `last_grant` is `NUM_CONSUMERS-1`.
  - All ready bits, all `read_data` entries and `busy` are 0.
  - All memory entries are cleared to 0.
- **Reset mid-request:** the request in flight is dropped with no ready pulse. A write that has not yet committed does not change memory (memory is cleared anyway).
- **Latency**
  - Valid sampled in IDLE at the end of cycle c0.
  - BUSY occupies cycles c1..cLATENCY.
  - Ready is high in cycle c(LATENCY+1).
  - The responder is back in IDLE in c(LATENCY+2) and can grant again in that cycle.
- **Occupancy:** `LATENCY+2` cycles per request. Back-to-back requests from different channels complete every `LATENCY+2` cycles.
- **Outputs:** ready and data are registered. There is no combinational path from input to output.
- **`busy`:** registered; high from c1 through c(LATENCY+1).

## Test plan
- **Reset then write:** reset, then ch0 write addr=0x10 data=0xAB (LATENCY=2) -> `write_ready[0]` high only in cycle c3 and `busy` high c1..c3. A subsequent ch0 read of 0x10 returns 0xAB with `read_ready[0]` pulsed once.
- **Round-robin:** all four channels assert reads of addresses 0x00..0x03 in the same cycle after reset -> grants in order ch0, ch1, ch2, ch3. Ready pulses are spaced 4 cycles apart, and each channel's data equals its address's memory contents (0 after reset).
- **No duplicate grant:** the LSU model drops valid one edge after seeing ready -> exactly one ready pulse per request, and `busy` is low for at least one cycle between requests.
- **Same-channel read and write:** ch2 asserts read 0x20 and write 0x20=0x55 simultaneously after reset -> the read is served first and returns 0x00, then the write completes. A later read returns 0x55.
- **Reset mid-operation:** async reset asserted in the middle of BUSY for a write 0x30=0x77 -> outputs are 0 immediately, no ready pulse appears, a read of 0x30 returns 0x00, and the first post-reset grant goes to ch0.
- **LATENCY=1 configuration:** ch1 write -> ready in c2; back-to-back ch0 and ch1 reads complete every 3 cycles.

Source files
------------

// File: rtl/lsu_mem_responder.sv
// Data-memory responder for the LSU valid/ready handshake: round-robin grant, one request
// at a time, fixed latency against an internal byte-addressed memory.
module lsu_mem_responder #(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned LATENCY       = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
  output logic                                      busy
);

  localparam int unsigned ChW   = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned Depth = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StBusy, StRespond} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [ChW-1:0]       last_grant_q, last_grant_d;
  logic [ChW-1:0]       ch_q, ch_d;
  logic                 is_write_q, is_write_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;

  logic [DATA_BITS-1:0] mem_q [Depth];
  logic [NUM_CONSUMERS-1:0]                read_ready_q, write_ready_q;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_q;

  logic           grant_valid;
  logic [ChW-1:0] grant_ch;
  logic           commit;

  // Search starts one past the last winner and wraps; first eligible channel wins.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_ch    = '0;
    for (int unsigned i = 1; i <= NUM_CONSUMERS; i++) begin
      idx = (int'(last_grant_q) + i) % NUM_CONSUMERS;
      if (!grant_valid && (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
        grant_valid = 1'b1;
        grant_ch    = idx[ChW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    ch_d         = ch_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d      = StBusy;
          ch_d         = grant_ch;
          // A pending read on the same channel goes ahead of its write.
          is_write_d   = !consumer_read_valid[grant_ch];
          addr_d       = consumer_read_valid[grant_ch] ? consumer_read_address[grant_ch]
                                                       : consumer_write_address[grant_ch];
          wdata_d      = consumer_write_data[grant_ch];
          count_d      = CntW'(LATENCY - 1);
          last_grant_d = grant_ch;
        end
      end
      StBusy: begin
        if (count_q != '0) count_d = count_q - CntW'(1);
        else               state_d = StRespond;
      end
      // Dead cycle: the LSU still holds valid while it samples ready, so never grant here.
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign commit = (state_q == StBusy) && (count_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      last_grant_q <= ChW'(NUM_CONSUMERS - 1);
      ch_q         <= '0;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      ch_q         <= ch_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_ready_q  <= '0;
      write_ready_q <= '0;
      read_data_q   <= '0;
    end else begin
      read_ready_q  <= '0;
      write_ready_q <= '0;
      if (commit) begin
        if (is_write_q) begin
          write_ready_q[ch_q] <= 1'b1;
        end else begin
          read_ready_q[ch_q] <= 1'b1;
          read_data_q[ch_q]  <= mem_q[addr_q];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (commit && is_write_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign consumer_read_ready  = read_ready_q;
  assign consumer_write_ready = write_ready_q;
  assign consumer_read_data   = read_data_q;
  assign busy                 = (state_q != StIdle);

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: LATENCY=2 and LATENCY=1 instances share stimulus;
// `sel` picks which one is observed.
module tb_lsu_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] rv = '0, wv = '0;
  logic [3:0][7:0] ra = '0, wa = '0, wd = '0;

  logic [3:0] rr0, wr0, rr1, wr1;
  logic [3:0][7:0] rd0, rd1;
  logic busy0, busy1;

  logic sel = 1'b0;
  logic [3:0] rr, wrr;
  logic [3:0][7:0] rd;
  logic bz;
  int lat;

  int n_cmp = 0;
  int n_fail = 0;

  int rd_first[4], rd_cnt[4], wr_first[4], wr_cnt[4];
  logic [7:0] rd_val[4];

  typedef struct {
    int         ch;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  lsu_mem_responder #(.NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(8), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(rr0), .consumer_read_data(rd0),
    .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd),
    .consumer_write_ready(wr0), .busy(busy0)
  );

  lsu_mem_responder #(.NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(rr1), .consumer_read_data(rd1),
    .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd),
    .consumer_write_ready(wr1), .busy(busy1)
  );

  always_comb begin
    rr  = sel ? rr1 : rr0;
    wrr = sel ? wr1 : wr0;
    rd  = sel ? rd1 : rd0;
    bz  = sel ? busy1 : busy0;
    lat = sel ? 1 : 2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    rv = '0;
    wv = '0;
    #1;
    chk("reset busy", {31'b0, bz}, 0);
    chk("reset ready", {24'b0, rr, wrr}, 0);
    chk("reset rdata", rd, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One request on one channel; LSU drops valid on the edge after seeing ready.
  task automatic do_req(input int ch, input bit wr, input logic [7:0] addr,
                        input logic [7:0] data, input logic [7:0] exp, input string tag);
    int n;
    bit got;
    logic [3:0] mask;
    mask = 4'b0001 << ch;
    @(posedge clk);
    #1;
    if (wr) begin
      wa[ch] = addr; wd[ch] = data; wv[ch] = 1'b1;
    end else begin
      ra[ch] = addr; rv[ch] = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if ((wr ? wrr[ch] : rr[ch]) === 1'b1) got = 1'b1;
      else chk({tag, " busy"}, {31'b0, bz}, 1);
    end
    chk({tag, " latency"}, n, lat + 1);
    chk({tag, " busy@ready"}, {31'b0, bz}, 1);
    chk({tag, " ready mask"}, {24'b0, rr, wrr}, wr ? {24'b0, 4'b0, mask} : {24'b0, mask, 4'b0});
    if (!wr) chk({tag, " rdata"}, rd[ch], exp);
    @(posedge clk);
    #1;
    if (wr) wv[ch] = 1'b0;
    else    rv[ch] = 1'b0;
    chk({tag, " gap busy"}, {31'b0, bz}, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk({tag, " no dup"}, {24'b0, rr, wrr}, 0);
    end
    if (!wr) chk({tag, " rdata hold"}, rd[ch], exp);
  endtask

  // Watch ncycles from c1; each ready drops that channel's valid one edge later.
  task automatic monitor(input int ncycles);
    logic [3:0] pend_r, pend_w;
    bit prev_rdy;
    pend_r = '0;
    pend_w = '0;
    prev_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rd_first[c] = -1; wr_first[c] = -1; rd_cnt[c] = 0; wr_cnt[c] = 0; rd_val[c] = 'x;
    end
    for (int n = 1; n <= ncycles; n++) begin
      @(posedge clk);
      #1;
      rv = rv & ~pend_r;
      wv = wv & ~pend_w;
      pend_r = '0;
      pend_w = '0;
      if (prev_rdy) chk("gap busy", {31'b0, bz}, 0);
      prev_rdy = |{rr, wrr};
      for (int c = 0; c < 4; c++) begin
        if (rr[c] === 1'b1) begin
          rd_cnt[c]++;
          if (rd_first[c] < 0) begin rd_first[c] = n; rd_val[c] = rd[c]; end
          pend_r[c] = 1'b1;
        end
        if (wrr[c] === 1'b1) begin
          wr_cnt[c]++;
          if (wr_first[c] < 0) wr_first[c] = n;
          pend_w[c] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{ch: 0, wr: 1'b1, addr: 8'h10, data: 8'hAB, exp: 8'h00};
    vecs[1] = '{ch: 0, wr: 1'b0, addr: 8'h10, data: 8'h00, exp: 8'hAB};
    vecs[2] = '{ch: 3, wr: 1'b1, addr: 8'hFF, data: 8'h5A, exp: 8'h00};
    vecs[3] = '{ch: 1, wr: 1'b0, addr: 8'hFF, data: 8'h00, exp: 8'h5A};
    vecs[4] = '{ch: 2, wr: 1'b1, addr: 8'h00, data: 8'hFF, exp: 8'h00};
    vecs[5] = '{ch: 3, wr: 1'b0, addr: 8'h00, data: 8'h00, exp: 8'hFF};
    vecs[6] = '{ch: 1, wr: 1'b0, addr: 8'h11, data: 8'h00, exp: 8'h00};

    #1;
    chk("power-on busy", {31'b0, bz}, 0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp,
             $sformatf("vec%0d", i));
    end

    // Round-robin: memory cleared by reset, so 0x00 (written 0xFF above) must read 0.
    do_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) ra[c] = 8'(c);
    rv = 4'hF;
    monitor(20);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rr ch%0d cycle", c), rd_first[c], 3 + 4 * c);
      chk($sformatf("rr ch%0d pulses", c), rd_cnt[c], 1);
      chk($sformatf("rr ch%0d data", c), {24'b0, rd_val[c]}, 0);
    end

    // Same channel read and write: read first with old data, then the write.
    do_reset();
    @(posedge clk);
    #1;
    ra[2] = 8'h20; wa[2] = 8'h20; wd[2] = 8'h55;
    rv[2] = 1'b1; wv[2] = 1'b1;
    monitor(12);
    chk("rw read cycle", rd_first[2], 3);
    chk("rw read data", {24'b0, rd_val[2]}, 0);
    chk("rw write cycle", wr_first[2], 7);
    chk("rw pulses", rd_cnt[2] + wr_cnt[2], 2);
    do_req(2, 1'b0, 8'h20, 8'h00, 8'h55, "rw readback");

    // Reset in the middle of a write.
    do_reset();
    do_req(1, 1'b1, 8'h40, 8'h99, 8'h00, "pre w");
    do_req(1, 1'b0, 8'h40, 8'h00, 8'h99, "pre r");
    @(posedge clk);
    #1;
    wa[1] = 8'h30; wd[1] = 8'h77; wv[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("mid busy before", {31'b0, bz}, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    wv = '0;
    #1;
    chk("mid busy", {31'b0, bz}, 0);
    chk("mid ready", {24'b0, rr, wrr}, 0);
    chk("mid rdata", rd, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    monitor(5);
    chk("mid no pulse", rd_cnt[1] + wr_cnt[1], 0);
    @(posedge clk);
    #1;
    ra[0] = 8'h30; ra[1] = 8'h40;
    rv[0] = 1'b1; rv[1] = 1'b1;
    monitor(12);
    chk("post ch0 first", rd_first[0], 3);
    chk("post ch1 second", rd_first[1], 7);
    chk("post 0x30 data", {24'b0, rd_val[0]}, 0);
    chk("post 0x40 data", {24'b0, rd_val[1]}, 0);

    // LATENCY=1 instance.
    sel = 1'b1;
    do_reset();
    do_req(1, 1'b1, 8'h50, 8'h3C, 8'h00, "l1 w");
    @(posedge clk);
    #1;
    ra[0] = 8'h51; ra[1] = 8'h50;
    rv[0] = 1'b1; rv[1] = 1'b1;
    monitor(10);
    chk("l1 ch0 cycle", rd_first[0], 2);
    chk("l1 ch1 cycle", rd_first[1], 5);
    chk("l1 ch0 data", {24'b0, rd_val[0]}, 0);
    chk("l1 ch1 data", {24'b0, rd_val[1]}, 32'h3C);
    chk("l1 pulses", rd_cnt[0] + rd_cnt[1], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
